// File: rtl/ones_frame_stats.sv
// rtl/ones_frame_stats.sv - per-frame sum/max/min/word-count statistics over population counts
module ones_frame_stats #(
    parameter int log_bit_width = 5,
    parameter int log_max_words = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [log_bit_width:0]                   count_in,
    input  logic                                     count_valid,
    input  logic                                     frame_last,
    output logic                                     count_ready,
    output logic [log_bit_width+log_max_words:0]     sum_out,
    output logic [log_bit_width:0]                   max_out,
    output logic [log_bit_width:0]                   min_out,
    output logic [log_max_words:0]                   words_out,
    output logic                                     ovf_out,
    output logic                                     res_valid,
    input  logic                                     res_ready
);
    localparam int CW = log_bit_width + 1;
    localparam int SW = log_bit_width + 1 + log_max_words;
    localparam int WW = log_max_words + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 ** log_bit_width);
    localparam logic [WW-1:0] WORD_MAX = WW'(2 ** log_max_words);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d, sum_out_q, sum_out_d;
    logic [CW-1:0] max_q, max_d, max_out_q, max_out_d;
    logic [CW-1:0] min_q, min_d, min_out_q, min_out_d;
    logic [WW-1:0] words_q, words_d, words_out_q, words_out_d;
    logic          ovf_q, ovf_d, ovf_out_q, ovf_out_d;
    logic          ready_q, ready_d, valid_q, valid_d;

    logic          accept;
    logic [CW-1:0] cnt;
    logic [SW-1:0] acc_sum;
    logic [CW-1:0] acc_max, acc_min;
    logic [WW-1:0] acc_words;
    logic          acc_ovf;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        max_d       = max_q;
        min_d       = min_q;
        words_d     = words_q;
        ovf_d       = ovf_q;
        sum_out_d   = sum_out_q;
        max_out_d   = max_out_q;
        min_out_d   = min_out_q;
        words_out_d = words_out_q;
        ovf_out_d   = ovf_out_q;

        accept = count_valid && ready_q;
        cnt    = (count_in > CNT_MAX) ? CNT_MAX : count_in;

        // Words past the limit only raise the sticky flag; the counter saturates at the limit.
        if (words_q < WORD_MAX) begin
            acc_sum   = sum_q + SW'(cnt);
            acc_max   = (words_q == '0 || cnt > max_q) ? cnt : max_q;
            acc_min   = (words_q == '0 || cnt < min_q) ? cnt : min_q;
            acc_words = words_q + WW'(1);
            acc_ovf   = ovf_q;
        end else begin
            acc_sum   = sum_q;
            acc_max   = max_q;
            acc_min   = min_q;
            acc_words = words_q;
            acc_ovf   = 1'b1;
        end

        if (accept) begin
            if (frame_last) begin
                sum_out_d   = acc_sum;
                max_out_d   = acc_max;
                min_out_d   = acc_min;
                words_out_d = acc_words;
                ovf_out_d   = acc_ovf;
                sum_d       = '0;
                max_d       = '0;
                min_d       = '0;
                words_d     = '0;
                ovf_d       = 1'b0;
                state_d     = HOLD;
            end else begin
                sum_d   = acc_sum;
                max_d   = acc_max;
                min_d   = acc_min;
                words_d = acc_words;
                ovf_d   = acc_ovf;
                state_d = ACCUM;
            end
        end

        if (state_q == HOLD && res_ready) begin
            state_d = IDLE;
        end

        ready_d = (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
            sum_out_q   <= '0;
            max_out_q   <= '0;
            min_out_q   <= '0;
            words_out_q <= '0;
            ovf_out_q   <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            min_q       <= min_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
            sum_out_q   <= sum_out_d;
            max_out_q   <= max_out_d;
            min_out_q   <= min_out_d;
            words_out_q <= words_out_d;
            ovf_out_q   <= ovf_out_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign count_ready = ready_q;
    assign res_valid   = valid_q;
    assign sum_out     = sum_out_q;
    assign max_out     = max_out_q;
    assign min_out     = min_out_q;
    assign words_out   = words_out_q;
    assign ovf_out     = ovf_out_q;
endmodule

// File: tb/tb_ones_frame_stats.sv
// tb/tb_ones_frame_stats.sv - self-checking bench: 256-word and 4-word instances on shared stimulus
module tb_ones_frame_stats;
    logic        clk, rst;
    logic [5:0]  count_in;
    logic        count_valid, frame_last, res_ready;

    logic        ready_a, valid_a, ovf_a;
    logic [13:0] sum_a;
    logic [5:0]  max_a, min_a;
    logic [8:0]  words_a;

    logic        ready_b, valid_b, ovf_b;
    logic [7:0]  sum_b;
    logic [5:0]  max_b, min_b;
    logic [2:0]  words_b;

    int n_vec = 0;
    int n_err = 0;

    ones_frame_stats #(.log_bit_width(5), .log_max_words(8)) u_dut_a (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .frame_last(frame_last), .count_ready(ready_a), .sum_out(sum_a),
        .max_out(max_a), .min_out(min_a), .words_out(words_a), .ovf_out(ovf_a),
        .res_valid(valid_a), .res_ready(res_ready)
    );

    ones_frame_stats #(.log_bit_width(5), .log_max_words(2)) u_dut_b (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .frame_last(frame_last), .count_ready(ready_b), .sum_out(sum_b),
        .max_out(max_b), .min_out(min_b), .words_out(words_b), .ovf_out(ovf_b),
        .res_valid(valid_b), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: keep the accepted (clamped) words, reduce them when the frame closes.
    int lim [2] = '{256, 4};
    int frame_q[$];
    bit pend = 0;
    int exp_sum [2], exp_max [2], exp_min [2], exp_words [2];
    bit exp_ovf [2];

    always @(negedge clk) begin
        if (!rst) begin
            pend = 0;
            frame_q.delete();
            check("rst_ready_a", ready_a, 1);
            check("rst_valid_a", valid_a, 0);
            check("rst_sum_a", sum_a, 0);
            check("rst_min_a", min_a, 0);
            check("rst_ready_b", ready_b, 1);
            check("rst_valid_b", valid_b, 0);
            check("rst_words_b", words_b, 0);
        end else begin
            check("ready_a", ready_a, !pend);
            check("valid_a", valid_a, pend);
            check("ready_b", ready_b, !pend);
            check("valid_b", valid_b, pend);
            if (pend) begin
                check("sum_a", sum_a, exp_sum[0]);
                check("max_a", max_a, exp_max[0]);
                check("min_a", min_a, exp_min[0]);
                check("words_a", words_a, exp_words[0]);
                check("ovf_a", ovf_a, exp_ovf[0]);
                check("sum_b", sum_b, exp_sum[1]);
                check("max_b", max_b, exp_max[1]);
                check("min_b", min_b, exp_min[1]);
                check("words_b", words_b, exp_words[1]);
                check("ovf_b", ovf_b, exp_ovf[1]);
                if (res_ready) pend = 0;
            end else if (count_valid) begin
                frame_q.push_back(count_in > 32 ? 32 : int'(count_in));
                if (frame_last) begin
                    for (int i = 0; i < 2; i++) begin
                        int n;
                        n = (frame_q.size() < lim[i]) ? frame_q.size() : lim[i];
                        exp_sum[i] = 0;
                        exp_max[i] = frame_q[0];
                        exp_min[i] = frame_q[0];
                        for (int k = 0; k < n; k++) begin
                            exp_sum[i] += frame_q[k];
                            if (frame_q[k] > exp_max[i]) exp_max[i] = frame_q[k];
                            if (frame_q[k] < exp_min[i]) exp_min[i] = frame_q[k];
                        end
                        exp_words[i] = n;
                        exp_ovf[i]   = (frame_q.size() > lim[i]);
                    end
                    frame_q.delete();
                    pend = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input bit last);
        count_valid = 1'b1;
        count_in    = 6'(c);
        frame_last  = last;
        step();
        count_valid = 1'b0;
        frame_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; count_in = '0; count_valid = 1'b0; frame_last = 1'b0; res_ready = 1'b1;
        step();
        step();
        check("init_ready", ready_a, 1);
        check("init_words", words_a, 0);
        rst = 1'b1;
        step();

        // basic frame: 3, 32, 0, 7
        send(3, 0); send(32, 0); send(0, 0); send(7, 1);
        check("basic_valid", valid_a, 1);
        check("basic_ready_low", ready_a, 0);
        check("basic_sum", sum_a, 42);
        check("basic_max", max_a, 32);
        check("basic_min", min_a, 0);
        check("basic_words", words_a, 4);
        check("basic_ovf", ovf_a, 0);
        step();
        check("basic_valid_drop", valid_a, 0);
        check("basic_ready_back", ready_a, 1);

        // single-word frame
        send(17, 1);
        check("single_sum", sum_a, 17);
        check("single_max", max_a, 17);
        check("single_min", min_a, 17);
        check("single_words", words_a, 1);
        step();

        // backpressure: inputs offered during HOLD must be ignored
        res_ready = 1'b0;
        send(10, 0); send(20, 1);
        for (int i = 0; i < 5; i++) begin
            count_valid = 1'b1; count_in = 6'd30; frame_last = 1'b1;
            step();
            check("bp_ready_low", ready_a, 0);
            check("bp_valid_hold", valid_a, 1);
            check("bp_sum_hold", sum_a, 30);
            check("bp_words_hold", words_a, 2);
        end
        count_valid = 1'b0; frame_last = 1'b0; res_ready = 1'b1;
        step();
        check("bp_release", ready_a, 1);
        send(5, 1);
        check("bp_next_sum", sum_a, 5);
        check("bp_next_words", words_a, 1);
        step();

        // overflow: six words of 1 against the 4-word instance
        for (int i = 0; i < 6; i++) send(1, i == 5);
        check("ovf_b_flag", ovf_b, 1);
        check("ovf_b_words", words_b, 4);
        check("ovf_b_sum", sum_b, 4);
        check("ovf_a_words", words_a, 6);
        check("ovf_a_flag", ovf_a, 0);
        step();
        send(2, 0); send(2, 1);
        check("ovf_b_cleared", ovf_b, 0);
        check("ovf_b_next_sum", sum_b, 4);
        step();

        // clamp: 40 counts as 32
        send(40, 0); send(1, 1);
        check("clamp_sum", sum_a, 33);
        check("clamp_max", max_a, 32);
        check("clamp_min", min_a, 1);
        step();

        // reset mid-frame
        send(4, 0); send(6, 0);
        rst = 1'b0;
        #1;
        check("rstmid_ready", ready_a, 1);
        check("rstmid_sum", sum_a, 0);
        check("rstmid_max", max_a, 0);
        step();
        rst = 1'b1;
        step();
        send(5, 1);
        check("rstmid_next_sum", sum_a, 5);
        check("rstmid_next_words", words_a, 1);
        step();

        // reset during HOLD
        res_ready = 1'b0;
        send(9, 1);
        check("rsthold_valid_pre", valid_a, 1);
        rst = 1'b0;
        #1;
        check("rsthold_valid", valid_a, 0);
        check("rsthold_ready", ready_a, 1);
        check("rsthold_sum", sum_a, 0);
        step();
        rst = 1'b1;
        res_ready = 1'b1;
        step();
        send(5, 1);
        check("rsthold_next_sum", sum_a, 5);
        check("rsthold_next_words", words_a, 1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ones_frame_stats.md
# ones_frame_stats

Frame statistics stage that sits directly downstream of the ones counter. It consumes one population-count value per accepted cycle and accumulates sum, maximum, minimum and word count over a frame delimited by `frame_last`. When a frame closes, it presents a registered result record on a valid/ready output handshake. It backpressures the upstream path while a result is pending.

## Interface
- `log_bit_width`, default 5: log2 of the upstream word width; `count_in` spans 0..2**log_bit_width.
- `log_max_words`, default 8: log2 of the maximum frame length in words (default 256).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low (asserted at 0); asynchronous assertion, synchronous deassertion provided externally.
- `count_in`  in  log_bit_width+1  population count of one word.
- `count_valid`  in  1  `count_in` and `frame_last` are valid this cycle.
- `frame_last`  in  1  this count is the final word of the frame.
- `count_ready`  out  1  block accepts input this cycle.
- `sum_out`  out  log_bit_width+1+log_max_words  total ones in the frame.
- `max_out`  out  log_bit_width+1  largest count in the frame.
- `min_out`  out  log_bit_width+1  smallest count in the frame.
- `words_out`  out  log_max_words+1  number of words counted.
- `ovf_out`  out  1  frame exceeded 2**log_max_words words.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  downstream takes the result.

## Operation
- Accept condition: `count_valid && count_ready`. Nothing changes on cycles without acceptance.
- Input clamp: an accepted `count_in` above 2**log_bit_width is treated as 2**log_bit_width.
- The FSM has three states:
  - IDLE: frame empty, `count_ready`=1.
  - ACCUM: frame open, `count_ready`=1.
  - HOLD: result pending, `count_ready`=0, `res_valid`=1.
- Transitions:
  - IDLE→ACCUM on an accept with `frame_last`=0.
  - IDLE→HOLD on an accept with `frame_last`=1 (single-word frame).
  - ACCUM→HOLD on an accept with `frame_last`=1.
  - ACCUM stays in ACCUM on an accept with `frame_last`=0.
  - HOLD→IDLE when `res_ready`=1.
- Accumulation on each accept while the word counter is below 2**log_max_words:
  - sum += count
  - max = max(max, count)
  - min = min(min, count); the first word of a frame loads max and min directly.
  - words += 1
- Overflow: an accept arriving when words = 2**log_max_words sets the sticky ovf flag. That word does not modify sum, max, min or words. Its `frame_last` still closes the frame. The sum width cannot wrap by construction.
- Frame close: the output registers load the final values, including the closing word when it is within the limit. Internal accumulators and the ovf flag clear in the same cycle.
- Output registers hold steady throughout HOLD; `res_valid` stays high until `res_ready` is sampled high.
- Reset (at any time, including mid-frame or during HOLD):
  - state returns to IDLE, accumulators clear, and the partial frame is discarded;
  - every output is 0, except `count_ready`=1 and `min_out`=0.

## Timing
- Latency: an accept of the closing word at edge N gives `res_valid`=1 with valid data after edge N.
- `count_ready` is a registered state decode. It falls in the same cycle `res_valid` rises.
- Handshake: `res_valid && res_ready` at edge M gives `res_valid`=0 and `count_ready`=1 after M. This leaves one forced bubble cycle per frame; there is no same-cycle bypass.
- `count_valid` asserted while `count_ready`=0 is ignored. Upstream holds or drops its data.
- `res_ready` asserted while `res_valid`=0 has no effect.
- Throughput: one word per cycle inside a frame; a new frame starts no earlier than the cycle after the result handshake.
- Upstream alignment: the ones counter's two-cycle latency is compensated outside this block. `count_valid` arrives already aligned.

## Test plan
- Basic frame (`log_bit_width`=5, `log_max_words`=8), with `res_ready` tied 1:
  - stimulus: counts 3, 32, 0, 7 on consecutive cycles, `frame_last` on the 7;
  - required: `res_valid`=1 for one cycle with sum=42, max=32, min=0, words=4, ovf=0; `count_ready` low for exactly one cycle.
- Single-word frame:
  - stimulus: count 17 with `frame_last`=1 from IDLE;
  - required: next cycle sum=17, max=17, min=17, words=1.
- Backpressure:
  - stimulus: after a frame closes, hold `res_ready`=0 for 5 cycles while driving `count_valid`=1;
  - required: outputs stable, `count_ready`=0, no input consumed; `res_ready`=1 then releases, and the next frame's stats exclude the ignored inputs.
- Overflow (`log_max_words`=2):
  - stimulus: 6 words of count 1, last flagged;
  - required: words=4, sum=4, ovf=1; the next frame shows ovf=0.
- Clamp: accepted `count_in`=40 (with `log_bit_width`=5) is counted as 32 in sum and max.
- Reset:
  - stimulus: assert `rst`=0 asynchronously mid-frame after 2 words, and again during HOLD;
  - required: all outputs go to reset values immediately with `count_ready`=1, and a following 1-word frame of 5 reports sum=5, words=1.
